adaptive_threshold: RTL and testbench

Final stage of the adaptive-thresholding pipeline, directly downstream of `box_filter`. Once the box filter has filled the middle RAM with local means, this block raster-scans the image. For each pixel it reads the original value from the input ROM and the local mean from the middle RAM at the same coordinate. It writes a binary pixel (255 or 0) to the result RAM, sustaining one pixel per clock after pipeline fill.

---
 rtl/adaptive_threshold_pkg.sv | 18 +
 rtl/adaptive_threshold_raster_counter.sv | 38 +++
 rtl/adaptive_threshold.sv | 127 ++++++++++++
 tb/tb_adaptive_threshold.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/adaptive_threshold_pkg.sv
// Shared constants for the adaptive-threshold pipeline: default image
// geometry, binary pixel values and the scan FSM state encoding.
package adaptive_threshold_pkg;

    localparam int DEF_WIDTH_BITS  = 8;
    localparam int DEF_HEIGHT_BITS = 8;

    localparam logic [7:0] PIX_WHITE = 8'd255;
    localparam logic [7:0] PIX_BLACK = 8'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/adaptive_threshold_raster_counter.sv
// Raster-order col/row counter, column fastest. Wraps to (0,0) after the
// last pixel and flags the last coordinate so the owner can end a scan.
module raster_counter
    import adaptive_threshold_pkg::*;
#(
    parameter int WIDTH_BITS  = DEF_WIDTH_BITS,
    parameter int HEIGHT_BITS = DEF_HEIGHT_BITS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    output logic [WIDTH_BITS-1:0]  col,
    output logic [HEIGHT_BITS-1:0] row,
    output logic                   last
);

    assign last = (&col) && (&row);

    // Advance one pixel per enabled cycle; row steps when the column wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (enable) begin
            if (&col) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adaptive_threshold.sv
// Final adaptive-threshold stage: raster-scans the image, compares each
// pixel with its local mean minus an offset and writes 255/0 to the result
// RAM at one pixel per clock, two cycles after the address is issued.
module adaptive_threshold
    import adaptive_threshold_pkg::*;
#(
    parameter int WIDTH_BITS  = DEF_WIDTH_BITS,
    parameter int HEIGHT_BITS = DEF_HEIGHT_BITS,
    parameter int OFFSET_C    = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oMeanCol,
    output logic [HEIGHT_BITS-1:0] oMeanRow,
    input  logic [7:0]             iMeanData,
    output logic [WIDTH_BITS-1:0]  oResultCol,
    output logic [HEIGHT_BITS-1:0] oResultRow,
    output logic [7:0]             oResultData,
    output logic                   oResultWren,
    output logic                   finished
);

    localparam logic signed [9:0] OFFSET_S = 10'(OFFSET_C);

    // 10-bit signed compare so a mean below the offset yields a negative
    // threshold (every pixel white) instead of wrapping to a large value.
    function automatic logic [7:0] binarize(input logic [7:0] pixel,
                                            input logic [7:0] mean);
        logic signed [9:0] thr;
        logic signed [9:0] pix;
        thr = $signed({2'b00, mean}) - OFFSET_S;
        pix = $signed({2'b00, pixel});
        return (pix > thr) ? PIX_WHITE : PIX_BLACK;
    endfunction

    state_t                   state;
    state_t                   nextState;
    logic                     drainCnt;
    logic                     startRun;
    logic                     scanEn;
    logic [WIDTH_BITS-1:0]    cntCol;
    logic [HEIGHT_BITS-1:0]   cntRow;
    logic                     cntLast;

    logic                     vld_p1;
    logic [WIDTH_BITS-1:0]    col_p1;
    logic [HEIGHT_BITS-1:0]   row_p1;

    assign startRun = iStart && ((state == IDLE) || (state == DONE));
    assign scanEn   = (state == RUN);
    assign finished = (state == DONE);

    // Both memories are read at the same coordinate straight from the counter.
    assign oImageCol = cntCol;
    assign oImageRow = cntRow;
    assign oMeanCol  = cntCol;
    assign oMeanRow  = cntRow;

    raster_counter #(
        .WIDTH_BITS  (WIDTH_BITS),
        .HEIGHT_BITS (HEIGHT_BITS)
    ) uCounter (
        .clock  (clock),
        .reset  (reset),
        .enable (scanEn),
        .clear  (startRun),
        .col    (cntCol),
        .row    (cntRow),
        .last   (cntLast)
    );

    // State register plus the two-cycle drain timer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            drainCnt <= 1'b0;
        end else begin
            state    <= nextState;
            drainCnt <= (state == DRAIN) ? ~drainCnt : 1'b0;
        end
    end

    // Next-state logic; iStart only matters in IDLE and DONE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (iStart)   nextState = RUN;
            RUN:     if (cntLast)  nextState = DRAIN;
            DRAIN:   if (drainCnt) nextState = DONE;
            DONE:    if (iStart)   nextState = RUN;
            default: nextState = IDLE;
        endcase
    end

    // Stage 1: address copy travels with the returning memory data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            col_p1 <= '0;
            row_p1 <= '0;
        end else begin
            vld_p1 <= scanEn;
            col_p1 <= cntCol;
            row_p1 <= cntRow;
        end
    end

    // Stage 2: registered write port to the result RAM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oResultWren <= 1'b0;
            oResultCol  <= '0;
            oResultRow  <= '0;
            oResultData <= PIX_BLACK;
        end else begin
            oResultWren <= vld_p1;
            oResultCol  <= col_p1;
            oResultRow  <= row_p1;
            oResultData <= vld_p1 ? binarize(iImageData, iMeanData) : PIX_BLACK;
        end
    end

endmodule

// File: tb/tb_adaptive_threshold.sv
// Directed bench for adaptive_threshold on a 4x4 image with behavioural
// 1-cycle-latency ROM/RAM models; a second instance with offset 0 covers
// the all-255 equality case.
module tb_adaptive_threshold;

    logic       clock = 1'b0;
    logic       reset;
    logic       iStart;

    logic [1:0] imgCol, imgRow, meanCol, meanRow, resCol, resRow;
    logic [7:0] imgData, meanData, resData;
    logic       resWren, fin;

    logic [1:0] imgCol2, imgRow2, meanCol2, meanRow2, resCol2, resRow2;
    logic [7:0] imgData2, meanData2, resData2;
    logic       resWren2, fin2;

    logic [7:0] imgMem  [16];
    logic [7:0] meanMem [16];
    logic [7:0] expData [16];

    int checks = 0;
    int errors = 0;
    int writes;

    always #5 clock = ~clock;

    adaptive_threshold #(.WIDTH_BITS(2), .HEIGHT_BITS(2), .OFFSET_C(5)) dut (
        .clock(clock), .reset(reset), .iStart(iStart),
        .oImageCol(imgCol), .oImageRow(imgRow), .iImageData(imgData),
        .oMeanCol(meanCol), .oMeanRow(meanRow), .iMeanData(meanData),
        .oResultCol(resCol), .oResultRow(resRow), .oResultData(resData),
        .oResultWren(resWren), .finished(fin)
    );

    adaptive_threshold #(.WIDTH_BITS(2), .HEIGHT_BITS(2), .OFFSET_C(0)) dutZero (
        .clock(clock), .reset(reset), .iStart(iStart),
        .oImageCol(imgCol2), .oImageRow(imgRow2), .iImageData(imgData2),
        .oMeanCol(meanCol2), .oMeanRow(meanRow2), .iMeanData(meanData2),
        .oResultCol(resCol2), .oResultRow(resRow2), .oResultData(resData2),
        .oResultWren(resWren2), .finished(fin2)
    );

    always @(posedge clock) begin
        imgData   <= imgMem[{imgRow, imgCol}];
        meanData  <= meanMem[{meanRow, meanCol}];
        imgData2  <= 8'd255;
        meanData2 <= 8'd255;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic loadUniform();
        for (int i = 0; i < 16; i++) begin
            imgMem[i]  = 8'd100;
            meanMem[i] = 8'd100;
            expData[i] = 8'd255;
        end
    endtask

    // Hand-computed pattern with offset 5.
    task automatic loadPattern();
        loadUniform();
        imgMem[0] = 8'd94;  expData[0] = 8'd0;    // 94 < 95
        imgMem[1] = 8'd95;  expData[1] = 8'd0;    // equal -> 0
        imgMem[2] = 8'd96;  expData[2] = 8'd255;  // 96 > 95
        imgMem[4] = 8'd0;   meanMem[4] = 8'd3; expData[4] = 8'd255; // thr = -2
        imgMem[5] = 8'd95;  expData[5] = 8'd0;
        imgMem[15] = 8'd50; expData[15] = 8'd0;
    endtask

    // One scan from a start pulse; pulseAt re-raises iStart mid-RUN,
    // abortAfter asserts reset once that many writes have been seen.
    task automatic runPass(input int pulseAt, input int abortAfter);
        int n;
        @(negedge clock);
        iStart = 1'b1;
        writes = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clock);
            #1;
            iStart = (cyc == pulseAt) ? 1'b1 : 1'b0;
            if (cyc == 1) begin
                check("first addr col", {30'd0, imgCol}, 32'd0);
                check("first addr row", {30'd0, imgRow}, 32'd0);
            end
            check("mean col tracks image", {30'd0, meanCol}, {30'd0, imgCol});
            check("mean row tracks image", {30'd0, meanRow}, {30'd0, imgRow});
            check("wren", {31'd0, resWren}, {31'd0, (cyc >= 3 && cyc <= 18)});
            check("finished", {31'd0, fin}, {31'd0, (cyc >= 19)});
            if (resWren) writes++;
            if (cyc >= 3 && cyc <= 18) begin
                n = cyc - 3;
                check("write col", {30'd0, resCol}, n % 4);
                check("write row", {30'd0, resRow}, n / 4);
                check("write data", {24'd0, resData}, {24'd0, expData[n]});
                check("zero-offset wren", {31'd0, resWren2}, 32'd1);
                check("zero-offset data", {24'd0, resData2}, 32'd0);
            end
            if (abortAfter > 0 && writes == abortAfter) begin
                #2 reset = 1'b1;
                #1;
                check("abort wren", {31'd0, resWren}, 32'd0);
                check("abort data", {24'd0, resData}, 32'd0);
                check("abort res col", {30'd0, resCol}, 32'd0);
                check("abort res row", {30'd0, resRow}, 32'd0);
                check("abort img col", {30'd0, imgCol}, 32'd0);
                check("abort mean row", {30'd0, meanRow}, 32'd0);
                check("abort finished", {31'd0, fin}, 32'd0);
                for (int k = 0; k < 3; k++) begin
                    @(posedge clock);
                    #1;
                    check("held-reset wren", {31'd0, resWren}, 32'd0);
                end
                @(negedge clock);
                reset = 1'b0;
                return;
            end
        end
        check("write count", writes, 32'd16);
        @(posedge clock);
        #1;
        check("finished holds", {31'd0, fin}, 32'd1);
        check("no extra write", {31'd0, resWren}, 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        iStart = 1'b0;
        loadUniform();
        repeat (3) @(posedge clock);
        #1;
        check("reset wren", {31'd0, resWren}, 32'd0);
        check("reset data", {24'd0, resData}, 32'd0);
        check("reset finished", {31'd0, fin}, 32'd0);
        check("reset img col", {30'd0, imgCol}, 32'd0);
        check("reset img row", {30'd0, imgRow}, 32'd0);
        check("reset res col", {30'd0, resCol}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("idle wren", {31'd0, resWren}, 32'd0);
        check("idle finished", {31'd0, fin}, 32'd0);

        // Uniform image, with a stray start pulse during RUN.
        runPass(6, 0);

        // Restart from DONE with the hand-computed pattern.
        loadPattern();
        runPass(0, 0);

        // Reset after the 5th write, then a fresh pass from IDLE.
        loadUniform();
        runPass(0, 5);
        check("post-reset finished", {31'd0, fin}, 32'd0);
        loadPattern();
        runPass(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
